// File: rtl/rv_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_mdu_pkg
//  Description : Shared definitions for the RV32M multiply/divide unit.
//                Holds the datapath width, the RV32M Funct3 encodings, the
//                controller state encoding and a small decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package rv_mdu_pkg;

    localparam int XLEN = 32;

    // RV32M operation encodings (Funct3 field)
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } state_t;

    // All divide/remainder encodings have Funct3[2] set.
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32m_mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32m_mdu_if
//  Description : Request/response bundle between the issuing execute stage
//                and the RV32M multiply/divide unit.
//                master : drives Start/Funct3/SrcA/SrcB/RdIn, observes results
//                slave  : the unit itself
//  Ports       : Start, Funct3[2:0], SrcA[31:0], SrcB[31:0], RdIn[4:0]
//                Busy, Done, Result[31:0], RdOut[4:0], WeOut
//  Revision    : 1.0  initial release
// ============================================================================
interface rv32m_mdu_if
    import rv_mdu_pkg::*;
();

    logic            Start;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [4:0]      RdIn;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;
    logic [4:0]      RdOut;
    logic            WeOut;

    modport master (
        output Start, Funct3, SrcA, SrcB, RdIn,
        input  Busy, Done, Result, RdOut, WeOut
    );

    modport slave (
        input  Start, Funct3, SrcA, SrcB, RdIn,
        output Busy, Done, Result, RdOut, WeOut
    );

endinterface
`default_nettype wire

// File: rtl/rv_mdu_signfix.sv
`default_nettype none
// ============================================================================
//  Module      : rv_mdu_signfix
//  Description : Combinational sign handling for the RV32M unit.
//                Operand side : magnitude selection per operation and the
//                               result-negate flag.
//                Result side  : final negate and selection of the product
//                               half, quotient or remainder.
//  Ports       : op_f3_i, op_a_i, op_b_i     -> mag_a_o, mag_b_o, neg_o
//                res_f3_i, res_neg_i, prod_i,
//                quo_i, rem_i                -> result_o
//  Revision    : 1.0  initial release
// ============================================================================
module rv_mdu_signfix
    import rv_mdu_pkg::*;
(
    input  logic [2:0]        op_f3_i,
    input  logic [XLEN-1:0]   op_a_i,
    input  logic [XLEN-1:0]   op_b_i,
    output logic [XLEN-1:0]   mag_a_o,
    output logic [XLEN-1:0]   mag_b_o,
    output logic              neg_o,

    input  logic [2:0]        res_f3_i,
    input  logic              res_neg_i,
    input  logic [2*XLEN-1:0] prod_i,
    input  logic [XLEN-1:0]   quo_i,
    input  logic [XLEN-1:0]   rem_i,
    output logic [XLEN-1:0]   result_o
);

    logic              w_signed_a;
    logic              w_signed_b;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [2*XLEN-1:0] w_prod_fix;

    // Operand conditioning. The magnitude of 0x80000000 wraps back to
    // 0x80000000 and is then used as an unsigned value.
    always_comb begin
        w_signed_a = (op_f3_i == F3_MULH) || (op_f3_i == F3_MULHSU) ||
                     (op_f3_i == F3_DIV)  || (op_f3_i == F3_REM);
        w_signed_b = (op_f3_i == F3_MULH) || (op_f3_i == F3_DIV) ||
                     (op_f3_i == F3_REM);
        w_neg_a    = w_signed_a & op_a_i[XLEN-1];
        w_neg_b    = w_signed_b & op_b_i[XLEN-1];
        mag_a_o    = w_neg_a ? (~op_a_i + 1'b1) : op_a_i;
        mag_b_o    = w_neg_b ? (~op_b_i + 1'b1) : op_b_i;

        // Product/quotient negate on differing signs; remainder follows the
        // dividend. Unsigned operations never have a negative operand here.
        case (op_f3_i)
            F3_MULH, F3_MULHSU, F3_DIV: neg_o = w_neg_a ^ w_neg_b;
            F3_REM:                     neg_o = w_neg_a;
            default:                    neg_o = 1'b0;
        endcase
    end

    // Result fix-up
    always_comb begin
        w_prod_fix = res_neg_i ? (~prod_i + 1'b1) : prod_i;
        case (res_f3_i)
            F3_MUL:                         result_o = w_prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:   result_o = w_prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:                result_o = res_neg_i ? (~quo_i + 1'b1) : quo_i;
            default:                        result_o = res_neg_i ? (~rem_i + 1'b1) : rem_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32m_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : rv32m_mdu
//  Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//                multiply and restoring divide, 32 iterations each; divide
//                by zero and signed overflow complete early. Result, RdOut,
//                WeOut drive the register file write port.
//  Ports       : CLK  - rising-edge clock
//                RST  - synchronous active-high reset
//                bus  - rv32m_mdu_if.slave request/response bundle
//  Revision    : 1.0  initial release
// ============================================================================
module rv32m_mdu
    import rv_mdu_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    rv32m_mdu_if.slave   bus
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state_q,  state_d;
    logic [5:0]        cnt_q,    cnt_d;
    logic [2:0]        f3_q,     f3_d;
    logic [4:0]        rd_q,     rd_d;
    logic              neg_q,    neg_d;
    logic              early_q,  early_d;
    logic [XLEN-1:0]   opb_q,    opb_d;     // multiplicand / divisor
    logic [2*XLEN-1:0] acc_q,    acc_d;     // product accumulator
    logic [XLEN-1:0]   rem_q,    rem_d;     // committed partial remainder
    logic [XLEN-1:0]   quo_q,    quo_d;     // dividend in, quotient out
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              we_q,     we_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_neg;
    logic [XLEN-1:0]   w_fix_result;

    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_trial;
    logic [XLEN-1:0]   w_div_rem_next;
    logic [XLEN-1:0]   w_div_quo_next;

    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN-1:0]   w_special_result;

    rv_mdu_signfix u_signfix (
        .op_f3_i   (bus.Funct3),
        .op_a_i    (bus.SrcA),
        .op_b_i    (bus.SrcB),
        .mag_a_o   (w_mag_a),
        .mag_b_o   (w_mag_b),
        .neg_o     (w_neg),
        .res_f3_i  (f3_q),
        .res_neg_i (neg_q),
        .prod_i    (w_mul_next),
        .quo_i     (w_div_quo_next),
        .rem_i     (w_div_rem_next),
        .result_o  (w_fix_result)
    );

    // One radix-2 multiply step: conditionally add the multiplicand into
    // the upper half, then shift the 65-bit {carry, acc} right by one. The
    // multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                     (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};
    end

    // One restoring divide step on the 33-bit partial remainder. The
    // committed remainder is always below the divisor, so 32 bits hold it;
    // only the shifted trial value needs the extra bit.
    always_comb begin
        w_div_shift = {rem_q, quo_q[XLEN-1]};
        w_div_trial = w_div_shift - {1'b0, opb_q};
        if (!w_div_trial[XLEN]) begin
            w_div_rem_next = w_div_trial[XLEN-1:0];
            w_div_quo_next = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            w_div_rem_next = w_div_shift[XLEN-1:0];
            w_div_quo_next = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    // Divide special cases resolved straight from the request operands
    always_comb begin
        w_div_zero = (bus.SrcB == '0);
        w_div_ovf  = ((bus.Funct3 == F3_DIV) || (bus.Funct3 == F3_REM)) &&
                     (bus.SrcA == 32'h8000_0000) && (bus.SrcB == 32'hFFFF_FFFF);
        case (bus.Funct3)
            F3_DIV:  w_special_result = w_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            F3_DIVU: w_special_result = 32'hFFFF_FFFF;
            F3_REM:  w_special_result = w_div_zero ? bus.SrcA : 32'h0000_0000;
            default: w_special_result = bus.SrcA;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        early_d  = early_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        done_d   = 1'b0;
        we_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    f3_d  = bus.Funct3;
                    rd_d  = bus.RdIn;
                    cnt_d = 6'd0;
                    if (f3_is_div(bus.Funct3) && (w_div_zero || w_div_ovf)) begin
                        // Result is loaded now; Done is raised from DONE on
                        // the following edge.
                        result_d = w_special_result;
                        early_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        neg_d   = w_neg;
                        opb_d   = w_mag_b;
                        acc_d   = {{XLEN{1'b0}}, w_mag_a};
                        rem_d   = '0;
                        quo_d   = w_mag_a;
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (f3_is_div(f3_q)) begin
                    rem_d = w_div_rem_next;
                    quo_d = w_div_quo_next;
                end else begin
                    acc_d = w_mul_next;
                end
                if (cnt_q == 6'd31) begin
                    result_d = w_fix_result;
                    done_d   = 1'b1;
                    we_d     = (rd_q != 5'd0);
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                if (early_q) begin
                    early_d = 1'b0;
                    done_d  = 1'b1;
                    we_d    = (rd_q != 5'd0);
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            early_q  <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            early_q  <= early_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Result = result_q;
    assign bus.RdOut  = rd_q;
    assign bus.WeOut  = we_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32m_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32m_mdu
//  Description : Directed self-checking bench for rv32m_mdu.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv32m_mdu;
    import rv_mdu_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    rv32m_mdu_if bus ();

    rv32m_mdu u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to completion. exp_lat counts edges
    // from the accepting edge to the edge that raises Done. poke >= 0 pulses
    // a second Start at that cycle of the wait.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_lat, input int poke);
        int   n;
        logic busy_ok;
        bus.Start  = 1'b1;
        bus.Funct3 = f3;
        bus.SrcA   = a;
        bus.SrcB   = b;
        bus.RdIn   = rd;
        step();
        // Inputs need only be valid at the accepting edge
        bus.Start  = 1'b0;
        bus.Funct3 = ~f3;
        bus.SrcA   = $urandom;
        bus.SrcB   = $urandom;
        bus.RdIn   = ~rd;
        n       = 0;
        busy_ok = 1'b1;
        while (!bus.Done && n < 40) begin
            if (!bus.Busy) busy_ok = 1'b0;
            if (n == poke) begin
                bus.Start  = 1'b1;
                bus.Funct3 = F3_MUL;
                bus.SrcA   = 32'd5;
                bus.SrcB   = 32'd5;
                bus.RdIn   = 5'd9;
            end
            step();
            bus.Start = 1'b0;
            n++;
        end
        chk_eq({tag, "/latency"}, n, exp_lat);
        chk_eq({tag, "/busy"}, {31'd0, busy_ok}, 32'd1);
        chk_eq({tag, "/result"}, bus.Result, exp);
        chk_eq({tag, "/rdout"}, {27'd0, bus.RdOut}, {27'd0, rd});
        chk_eq({tag, "/weout"}, {31'd0, bus.WeOut}, {31'd0, (rd != 5'd0)});
        step();
        chk_eq({tag, "/done_drop"}, {31'd0, bus.Done}, 32'd0);
        chk_eq({tag, "/busy_drop"}, {31'd0, bus.Busy}, 32'd0);
    endtask

    initial begin
        int n_done;
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        bus.Start  = 1'b0;
        bus.Funct3 = 3'd0;
        bus.SrcA   = 32'd0;
        bus.SrcB   = 32'd0;
        bus.RdIn   = 5'd0;
        step();
        step();
        // Start during reset must not be taken
        bus.Start  = 1'b1;
        bus.Funct3 = F3_MUL;
        bus.SrcA   = 32'd3;
        bus.SrcB   = 32'd3;
        bus.RdIn   = 5'd3;
        step();
        chk_eq("reset/busy",   {31'd0, bus.Busy},  32'd0);
        chk_eq("reset/done",   {31'd0, bus.Done},  32'd0);
        chk_eq("reset/weout",  {31'd0, bus.WeOut}, 32'd0);
        chk_eq("reset/result", bus.Result,         32'd0);
        chk_eq("reset/rdout",  {27'd0, bus.RdOut}, 32'd0);
        bus.Start = 1'b0;
        rst       = 1'b0;
        step();

        // Multiplies
        run_op("mul",      F3_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 32, -1);
        run_op("mulhu",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 32, -1);
        run_op("mulh",     F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 32, -1);
        run_op("mulhsu",   F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 32, -1);
        run_op("mulh_neg", F3_MULH,   32'hFFFF_FFFD, 32'd5,         5'd9, 32'hFFFF_FFFF, 32, -1);

        // Divides
        run_op("div",      F3_DIV,  32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 32, -1);
        run_op("rem",      F3_REM,  32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 32, -1);
        run_op("divu",     F3_DIVU, 32'd100,       32'd7, 5'd12, 32'd14,        32, -1);
        run_op("remu",     F3_REMU, 32'd100,       32'd7, 5'd13, 32'd2,         32, -1);
        run_op("div_min1", F3_DIV,  32'h8000_0000, 32'd1, 5'd14, 32'h8000_0000, 32, -1);

        // Early-out special cases
        run_op("div0",    F3_DIV,  32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1, -1);
        run_op("rem0",    F3_REM,  32'd5,         32'd0,         5'd16, 32'd5,         1, -1);
        run_op("divu0",   F3_DIVU, 32'd5,         32'd0,         5'd17, 32'hFFFF_FFFF, 1, -1);
        run_op("remu0",   F3_REMU, 32'd7,         32'd0,         5'd18, 32'd7,         1, -1);
        run_op("div_ovf", F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1, -1);
        run_op("rem_ovf", F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         1, -1);

        // x0 destination, with a Start pulsed mid-CALC that must be ignored
        run_op("rd0", F3_MUL, 32'd3, 32'd4, 5'd0, 32'd12, 32, 10);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.Done) n_done++;
        end
        chk_eq("rd0/no_queued_done", n_done, 32'd0);
        chk_eq("rd0/result_held", bus.Result, 32'd12);

        // Reset in the middle of a DIVU
        bus.Start  = 1'b1;
        bus.Funct3 = F3_DIVU;
        bus.SrcA   = 32'd1000;
        bus.SrcB   = 32'd3;
        bus.RdIn   = 5'd21;
        step();
        bus.Start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_eq("rstmid/busy",   {31'd0, bus.Busy},  32'd0);
        chk_eq("rstmid/done",   {31'd0, bus.Done},  32'd0);
        chk_eq("rstmid/result", bus.Result,         32'd0);
        chk_eq("rstmid/rdout",  {27'd0, bus.RdOut}, 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.Done) n_done++;
        end
        chk_eq("rstmid/no_done", n_done, 32'd0);
        run_op("divu_after", F3_DIVU, 32'd1000, 32'd3, 5'd22, 32'd333, 32, -1);
        run_op("remu_after", F3_REMU, 32'd1000, 32'd3, 5'd23, 32'd1,   32, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
